// File: rtl/vga_timing_gen.sv
// Raster timing generator with raw X/Y counters, registered sync/blank outputs,
// and an optional external frame-sync mode with lock tracking and a wait-line timeout.
module vga_timing_gen #(
    parameter int H_VISIBLE      = 1024,
    parameter int H_FRONT_PORCH  = 40,
    parameter int H_SYNC_PULSE   = 104,
    parameter int H_BACK_PORCH   = 144,
    parameter int V_VISIBLE      = 600,
    parameter int V_FRONT_PORCH  = 1,
    parameter int V_SYNC_PULSE   = 3,
    parameter int V_BACK_PORCH   = 18,
    parameter int CW             = 12,
    parameter bit HS_POL         = 1'b0,
    parameter bit VS_POL         = 1'b1,
    parameter int MAX_WAIT_LINES = 64,
    parameter int LOCK_FRAMES    = 2
) (
    input  logic          VIDEO_CLK,
    input  logic          RESET_N,
    input  logic          ENABLE,
    input  logic          SYNC_EN,
    input  logic          SYNC,
    output logic [CW-1:0] X_O,
    output logic [CW-1:0] Y_O,
    output logic          HS,
    output logic          VS,
    output logic          DE,
    output logic          VISIBLE_X,
    output logic          VISIBLE_Y,
    output logic          FRAME_START,
    output logic          LOCKED,
    output logic          SYNC_MISSED,
    output logic [15:0]   FRAME_CNT
);
    localparam int H_BLANK = H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int H_TOTAL = H_BLANK + H_VISIBLE;
    localparam int V_BLANK = V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam int V_TOTAL = V_BLANK + V_VISIBLE;
    localparam int WW      = $clog2(MAX_WAIT_LINES + 1);
    localparam int LW      = $clog2(LOCK_FRAMES + 1);

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_FRONT_PORCH);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_FRONT_PORCH + H_SYNC_PULSE);
    localparam logic [CW-1:0] H_BLANK_C  = CW'(H_BLANK);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] V_WAIT     = CW'(V_TOTAL);
    localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_FRONT_PORCH);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_FRONT_PORCH + V_SYNC_PULSE);
    localparam logic [CW-1:0] V_BLANK_C  = CW'(V_BLANK);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(MAX_WAIT_LINES - 1);
    localparam logic [LW-1:0] LOCK_MAX   = LW'(LOCK_FRAMES);
    localparam logic [LW-1:0] LOCK_PRE   = LW'(LOCK_FRAMES - 1);

    logic [CW-1:0] x, y;
    logic [WW-1:0] wait_cnt;
    logic [LW-1:0] lock_cnt;
    logic          sen_q, pend, sync_q, locked_q, miss_q;

    logic eol, sync_edge, pending, sync_restart, timeout, restart, at_origin;

    always_comb begin
        eol          = ENABLE && (x == H_LAST);
        sync_edge    = SYNC && !sync_q;
        pending      = sen_q && (pend || sync_edge);
        sync_restart = eol && pending;
        timeout      = eol && sen_q && !pending && (y == V_WAIT) && (wait_cnt == WAIT_LAST);
        restart      = sync_restart || timeout || (eol && !sen_q && (y >= V_LAST));
        at_origin    = (x == '0) && (y == '0);
    end

    // Raw counters and mode state; everything advances only on ENABLE.
    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            x        <= '0;
            y        <= '0;
            wait_cnt <= '0;
            lock_cnt <= '0;
            sen_q    <= 1'b0;
            pend     <= 1'b0;
            sync_q   <= 1'b0;
            locked_q <= 1'b0;
            miss_q   <= 1'b0;
        end else if (ENABLE) begin
            sync_q <= SYNC;
            miss_q <= timeout;
            x      <= eol ? '0 : x + 1'b1;
            if (restart) begin
                y        <= '0;
                sen_q    <= SYNC_EN;
                pend     <= 1'b0;
                wait_cnt <= '0;
                if (sync_restart) begin
                    if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + 1'b1;
                    if (lock_cnt >= LOCK_PRE) locked_q <= 1'b1;
                end else begin
                    lock_cnt <= '0;
                    locked_q <= 1'b0;
                end
            end else begin
                pend <= pending;
                if (eol) begin
                    if (y < V_LAST) begin
                        y <= y + 1'b1;
                    end else begin
                        // Park on the blank wait line until SYNC arrives or the timeout fires.
                        y <= V_WAIT;
                        if (y == V_WAIT) wait_cnt <= wait_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Output stage: levels freeze with ENABLE low, pulses are qualified by ENABLE.
    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            HS          <= ~HS_POL;
            VS          <= ~VS_POL;
            DE          <= 1'b0;
            VISIBLE_X   <= 1'b0;
            VISIBLE_Y   <= 1'b0;
            X_O         <= '0;
            Y_O         <= '0;
            FRAME_START <= 1'b0;
            LOCKED      <= 1'b0;
            SYNC_MISSED <= 1'b0;
            FRAME_CNT   <= '0;
        end else begin
            FRAME_START <= ENABLE && at_origin;
            SYNC_MISSED <= ENABLE && miss_q;
            if (ENABLE) begin
                HS        <= (x >= H_SYNC_BEG && x < H_SYNC_END) ? HS_POL : ~HS_POL;
                VS        <= (y >= V_SYNC_BEG && y < V_SYNC_END) ? VS_POL : ~VS_POL;
                VISIBLE_X <= (x >= H_BLANK_C);
                VISIBLE_Y <= (y >= V_BLANK_C) && (y <= V_LAST);
                DE        <= (x >= H_BLANK_C) && (y >= V_BLANK_C) && (y <= V_LAST);
                X_O       <= x - H_BLANK_C;
                Y_O       <= y - V_BLANK_C;
                LOCKED    <= locked_q;
                if (at_origin) FRAME_CNT <= FRAME_CNT + 1'b1;
            end
        end
    end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters H_VISIBLE 1024, H_FRONT_PORCH 40, H_SYNC_PULSE 104, H_BACK_PORCH 144: horizontal timing in pixels.
REQ-002 SHALL have parameters V_VISIBLE 600, V_FRONT_PORCH 1, V_SYNC_PULSE 3, V_BACK_PORCH 18: vertical timing in lines.
REQ-003 SHALL have parameter CW 12: counter and position width, sized to hold H_TOTAL-1 and V_TOTAL.
REQ-004 SHALL have parameters HS_POL 0 and VS_POL 1: asserted sync level.
REQ-005 SHALL have parameter MAX_WAIT_LINES 64 (minimum 1): the sync-mode timeout in wait lines.
REQ-006 SHALL have parameter LOCK_FRAMES 2 (minimum 1): consecutive SYNC-started frames needed to assert LOCKED.
REQ-007 SHALL have ports VIDEO_CLK in 1: pixel clock; RESET_N in 1: reset, asynchronous, active-low.
REQ-008 SHALL have ports ENABLE in 1: advance counters; SYNC_EN in 1: request sync mode; SYNC in 1: frame-start request, synchronous to VIDEO_CLK.
REQ-009 SHALL have ports X_O out CW and Y_O out CW: active-region position.
REQ-010 SHALL have ports HS, VS, DE, VISIBLE_X, VISIBLE_Y out 1 each: syncs, data enable, per-axis visible.
REQ-011 SHALL have ports FRAME_START out 1, LOCKED out 1, SYNC_MISSED out 1, FRAME_CNT out 16.

Function
REQ-012 SHALL define H_BLANK = H_FRONT_PORCH+H_SYNC_PULSE+H_BACK_PORCH, H_TOTAL = H_BLANK+H_VISIBLE, and V_BLANK/V_TOTAL likewise.
REQ-013 SHALL keep raw counters X and Y; per axis, the order from 0 SHALL be front porch, sync, back porch, visible.
REQ-014 SHALL hold X, Y and all mode state while ENABLE=0; when ENABLE=1, X SHALL increment, wrapping to 0 after H_TOTAL-1 (end of line, EOL).
REQ-015 SHALL compute all outputs from X/Y and register them, giving exactly 1 cycle of latency and mutual alignment.
REQ-016 SHALL drive HS=HS_POL when H_FRONT_PORCH <= X < H_FRONT_PORCH+H_SYNC_PULSE, else ~HS_POL; VS SHALL follow the same rule with Y and VS_POL.
REQ-017 SHALL drive VISIBLE_X high for H_BLANK <= X < H_TOTAL and VISIBLE_Y high for V_BLANK <= Y < V_TOTAL; DE SHALL equal VISIBLE_X AND VISIBLE_Y.
REQ-018 SHALL drive X_O = X-H_BLANK and Y_O = Y-V_BLANK modulo 2^CW; X_O and Y_O are valid only when DE=1.
REQ-019 SHALL latch sync-mode bit SEN_Q from SYNC_EN only at a frame restart (Y->0); SEN_Q=0 selects free-run mode.
REQ-020 SHALL set sticky pending bit PEND on SYNC rising edge when SEN_Q=1; PEND SHALL be cleared at every frame restart and whenever SEN_Q=0.
REQ-021 SHALL treat an edge arriving in the EOL cycle as pending (PEND OR edge).
REQ-022 SHALL, in free-run mode at EOL, set Y to 0 if Y=V_TOTAL-1, else increment Y.
REQ-023 SHALL, in sync mode at EOL, restart the frame (Y->0) if pending, on any line.
REQ-024 SHALL, in sync mode at EOL with no pending edge, increment Y if Y<V_TOTAL-1, and go to or stay on wait line Y=V_TOTAL otherwise, counting wait lines.
REQ-025 SHALL drive the wait line as fully blanked: DE=0 and VS deasserted.
REQ-026 SHALL, when the wait-line count reaches MAX_WAIT_LINES, force a frame restart, pulse SYNC_MISSED high for 1 cycle and clear LOCKED.
REQ-027 SHALL count consecutive SYNC-started restarts, assert LOCKED at LOCK_FRAMES, and clear the count and LOCKED on timeout or on a restart with SEN_Q=0.
REQ-028 SHALL pulse FRAME_START for exactly 1 cycle, aligned with outputs for X=0,Y=0, and increment FRAME_CNT at the same time, wrapping at 16 bits.

Reset
REQ-029 SHALL, on RESET_N low, asynchronously set X=0, Y=0, SEN_Q=0, PEND=0, the wait and lock counters to 0, and FRAME_CNT=0.
REQ-030 SHALL, on RESET_N low, drive HS=~HS_POL, VS=~VS_POL, DE=VISIBLE_X=VISIBLE_Y=0, X_O=Y_O=0, FRAME_START=LOCKED=SYNC_MISSED=0.
REQ-031 SHALL resume counting from X=0,Y=0 on the first ENABLE edge after RESET_N deasserts.

Verification (params H 8/2/3/3 giving H_TOTAL 16; V 4/1/2/1 giving V_TOTAL 8; MAX_WAIT_LINES 4; LOCK_FRAMES 2)
REQ-032 SHALL cover free run: release reset, ENABLE=1 -> HS low while X=2..4 (1 cycle later), DE high for X 8..15 on Y 4..7, FRAME_START every 128 cycles.
REQ-033 SHALL cover mode latch: SYNC_EN=1 mid-frame -> no effect until next restart; then SYNC pulse while Y=5 -> Y=0 after that line's EOL, FRAME_CNT+1.
REQ-034 SHALL cover late sync: no SYNC -> Y holds at 8, DE=0; SYNC in wait line 2 -> restart at that EOL; second such frame -> LOCKED=1.
REQ-035 SHALL cover timeout: SYNC absent -> after 4 wait lines restart, SYNC_MISSED 1-cycle pulse, LOCKED=0.
REQ-036 SHALL cover simultaneous event: SYNC edge exactly in the EOL cycle -> restart at that EOL.
REQ-037 SHALL cover hold and reset: ENABLE=0 -> X/Y and outputs frozen; RESET_N low mid-line -> REQ-030 values same cycle, no clock needed.
